// File: rtl/rtc_bus_responder.sv
// Responder side of the multiplexed 8-bit RTC bus.
// Holds a BCD time register file plus scratch registers, driven by a 1 s tick.
module rtc_bus_responder #(
    parameter int TICK_DIV    = 100_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       a_d,
    input  logic       c_s,
    input  logic       r_d,
    input  logic       w_r,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       sec_pulse
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [7:0] LO [6] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};
    localparam logic [7:0] HI [6] = '{8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99};

    typedef enum logic [1:0] {IDLE, ADDR, WDATA, READ} state_t;

    state_t      state, state_n;
    logic [3:0]  st_sh [SYNC_STAGES];
    logic [7:0]  ad_sh [SYNC_STAGES];
    logic        a_d_s, c_s_s, r_d_s, w_r_s;
    logic [7:0]  ad_s;
    logic        cs, rd_act, latch, commit;
    logic [7:0]  addr;
    logic [7:0]  regs [16];
    logic [7:0]  tk [6];
    logic [CW-1:0] cnt;
    logic        wrap, tick_pend, apply;

    // Strobes idle high in reset so release never looks like an edge.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                st_sh[i] <= 4'b0111;
                ad_sh[i] <= 8'h00;
            end
        end else begin
            st_sh[0] <= {a_d, c_s, r_d, w_r};
            ad_sh[0] <= ad_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                st_sh[i] <= st_sh[i-1];
                ad_sh[i] <= ad_sh[i-1];
            end
        end
    end

    assign {a_d_s, c_s_s, r_d_s, w_r_s} = st_sh[SYNC_STAGES-1];
    assign ad_s   = ad_sh[SYNC_STAGES-1];
    assign cs     = ~c_s_s;
    assign rd_act = cs & a_d_s & ~r_d_s & w_r_s;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        latch   = 1'b0;
        commit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rd_act)
                    state_n = READ;
                else if (cs & ~a_d_s & ~w_r_s)
                    state_n = ADDR;
                else if (cs & a_d_s & ~w_r_s & r_d_s)
                    state_n = WDATA;
            end
            ADDR: begin
                if (!cs || a_d_s || !r_d_s) begin
                    state_n = IDLE;
                end else if (w_r_s) begin
                    state_n = IDLE;
                    latch   = 1'b1;
                end
            end
            WDATA: begin
                if (!cs || !a_d_s || !r_d_s) begin
                    state_n = IDLE;
                end else if (w_r_s) begin
                    state_n = IDLE;
                    commit  = (addr[7:4] == 4'h0);
                end
            end
            READ: begin
                if (!rd_act) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    function automatic logic [8:0] bcd_inc(input logic [7:0] v,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi);
        logic ok;
        ok = (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9);
        if (!ok || v >= hi)
            return {1'b1, lo};
        else if (v[3:0] == 4'd9)
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin : tick_calc
        logic       cy;
        logic [8:0] r;
        cy = 1'b1;
        r  = 9'h000;
        for (int i = 0; i < 6; i++) begin
            r     = bcd_inc(regs[i], LO[i], HI[i]);
            tk[i] = cy ? r[7:0] : regs[i];
            cy    = cy & r[8];
        end
    end

    assign wrap  = (cnt == CW'(TICK_DIV - 1));
    assign apply = tick_pend & ~commit;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            tick_pend <= 1'b0;
            sec_pulse <= 1'b0;
        end else begin
            cnt       <= wrap ? '0 : cnt + CW'(1);
            tick_pend <= wrap | (tick_pend & ~apply);
            sec_pulse <= apply;
        end
    end

    // A bus write takes the cycle; the pending tick lands on the next one.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            addr <= 8'h00;
            for (int i = 0; i < 16; i++)
                regs[i] <= (i == 3 || i == 4) ? 8'h01 : 8'h00;
        end else begin
            if (latch)
                addr <= ad_s;
            if (commit)
                regs[addr[3:0]] <= ad_s;
            else if (apply)
                for (int i = 0; i < 6; i++)
                    regs[i] <= tk[i];
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            ad_oe  <= 1'b0;
            ad_out <= 8'h00;
        end else begin
            ad_oe <= rd_act;
            if (rd_act)
                ad_out <= (addr[7:4] == 4'h0) ? regs[addr[3:0]] : 8'h00;
        end
    end

endmodule
